image_boot_ctrl: RTL
====================

# image_boot_ctrl

Boot and run sequencer for the single-cycle CPU. It consumes the instruction image and then the data image as a 32-bit word stream, and splits each word into big-endian byte writes into instruction memory and data memory. It loads the start PC and `$sp`, zero-fills the unused data memory, then releases the CPU. While the CPU runs, it counts cycles and stops the CPU on halt, address overflow or misalignment.

## Interface
- `IMEM_BYTES`, 1024: instruction memory size in bytes (power of 2).
- `DMEM_BYTES`, 1024: data memory size in bytes (power of 2).
- `SP_REG`, 29: register index loaded from the data-image header.

- `clk_i` in 1: single clock; all state changes on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `in_valid_i` in 1: image word valid.
- `in_ready_o` out 1: block accepts a word; a transfer occurs when both valid and ready are high at a rising edge.
- `in_data_i` in 32: image word.
- `imem_we_o` / `imem_addr_o` / `imem_data_o` out 1 / log2(IMEM_BYTES) / 8: instruction memory byte write.
- `dmem_we_o` / `dmem_addr_o` / `dmem_data_o` out 1 / log2(DMEM_BYTES) / 8: data memory byte write.
- `pc_we_o` / `pc_o` out 1 / 32: PC load pulse and value.
- `rf_we_o` / `rf_addr_o` / `rf_data_o` out 1 / 5 / 32: register file write (SP load).
- `cpu_rst_n_o` out 1: CPU reset; low until loading completes.
- `cpu_clk_en_o` out 1: CPU clock enable; high only in RUN.
- `halt_i`, `err_addr_i`, `err_miss_i` in 1 each: CPU halt opcode, address overflow, misalignment.
- `done_o` out 1: CPU stopped normally.
- `fault_o` out 1: image rejected.
- `cycle_cnt_o` out 32: number of RUN cycles.

## Operation
- Reset value of every output is 0; the FSM enters I_PC.
- State sequence: I_PC → I_CNT → (I_WORD ↔ I_BYTE)* → D_SP → D_CNT → (D_WORD ↔ D_BYTE)* → D_CLEAR → RUN → STOP. FAULT is terminal.
- I_PC: on transfer, latch `pc_o = in_data_i`, pulse `pc_we_o` for one cycle, and set the byte pointer to `in_data_i mod IMEM_BYTES`.
- I_CNT: on transfer, latch N.
  - N=0: go to D_SP.
  - N·4 > IMEM_BYTES: go to FAULT.
  - Otherwise: go to I_WORD.
- I_WORD: accept one word, then go to I_BYTE. I_BYTE emits 4 byte writes on consecutive cycles, MSB first, at pointer, pointer+1, +2, +3. The pointer wraps modulo IMEM_BYTES. After the 4th byte, the block returns to I_WORD, or goes to D_SP once N words are done.
- D_SP: on transfer, write `rf_addr_o=SP_REG` and `rf_data_o=in_data_i` with a one-cycle `rf_we_o` pulse.
- D_CNT: latch M. M·4 > DMEM_BYTES goes to FAULT; M=0 goes to D_CLEAR.
- D_WORD/D_BYTE: as for the instruction image. Word i writes bytes at addresses 4i..4i+3, MSB at 4i.
- D_CLEAR: write 0x00 to addresses 4M .. DMEM_BYTES−1, one per cycle. If 4M = DMEM_BYTES, the state lasts zero cycles and the block moves straight to RUN.
- RUN: `cpu_rst_n_o=1` and `cpu_clk_en_o=1`; `cycle_cnt_o` increments each cycle, saturating at 0xFFFFFFFF.
- If `halt_i`, `err_addr_i` or `err_miss_i` is high at an edge in RUN, that cycle is still counted and the block then enters STOP.
- STOP: `cpu_clk_en_o=0`, `cpu_rst_n_o` stays 1 (CPU state is kept for the dump), and `done_o=1`.
- FAULT: `fault_o=1`, `cpu_rst_n_o=0`. Only reset leaves FAULT.
- Simultaneous halt and error in RUN are handled identically: single transition to STOP.

## Timing
- `in_ready_o` is high only in I_PC, I_CNT, I_WORD, D_SP, D_CNT and D_WORD, and is driven from state only (registered, no combinational path from `in_valid_i`).
- Each payload word costs 5 cycles: 1 accept plus 4 byte writes. Throughput is therefore 1 word per 5 cycles with valid held high.
- Byte-write outputs are registered. The first byte write is asserted in the cycle after the accepting edge.
- `pc_we_o` and `rf_we_o` are asserted in the cycle after their accepting edge and last exactly one cycle.
- `cpu_rst_n_o` rises in the first RUN cycle. `cycle_cnt_o` = 1 after the first RUN edge.
- Reset asserted mid-load or mid-run: all outputs go to 0 immediately, with no further memory writes. Memories are not cleared by this block on reset.
- `in_valid_i` low in an accepting state: the block waits indefinitely with no timeout.

## Test plan
- Instruction load: stream PC=0x0000_0004, N=2, words 0x2008_0005 and 0xFC00_0000.
  - Required: `pc_we_o` with 0x4.
  - Required imem writes: @4=0x20, @5=0x08, @6=0x00, @7=0x05, @8=0xFC, @9..@11=0x00.
  - Required: exactly 10 accept cycles of latency to D_SP.
- Data load and clear: SP=0x0000_0400, M=1, word 0xDEADBEEF.
  - Required: `rf_we_o` to register 29 with 0x400.
  - Required dmem writes: @0..@3 = DE, AD, BE, EF, then 1020 zero writes @4..@1023.
  - Required: RUN entered.
- Run/halt: assert `halt_i` on the 7th RUN edge. Required: `cycle_cnt_o`=7, `done_o`=1, `cpu_clk_en_o`=0 and `cpu_rst_n_o`=1 thereafter.
- Bounds and wrap:
  - N=257 with IMEM_BYTES=1024 → FAULT, no imem writes.
  - PC=0x3FC with N=2 → second word written at 0x000..0x003 (wrap).
- Backpressure: deassert `in_valid_i` for 3 cycles in D_WORD. Required: no dmem writes in that window and correct byte order afterwards.
- Reset mid-load: drop `rst_i` during I_BYTE byte 2. Required: all outputs 0 immediately; after release, a fresh stream starting with the PC header loads correctly.

Source files
------------

// File: rtl/image_boot_ctrl.sv
// image_boot_ctrl
//
// Boot and run sequencer for the single-cycle CPU. Consumes an instruction
// image followed by a data image as a 32-bit word stream. Each payload word is
// split into four big-endian byte writes. The sequencer loads the start PC and
// the stack pointer, zero-fills the unused data memory and then releases the
// CPU. While the CPU runs it counts cycles. It stops the CPU on halt, on an
// address overflow or on a misaligned access.
//
// Image layout:
//   instruction image: PC, N, N payload words (placed at PC mod IMEM_BYTES)
//   data image:        SP, M, M payload words (placed at address 0)
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-low reset
//   in_valid_i/in_ready_o/in_data_i  image word stream (valid/ready handshake)
//   imem_we_o/addr_o/data_o          instruction memory byte write
//   dmem_we_o/addr_o/data_o          data memory byte write
//   pc_we_o/pc_o                     PC load pulse and value
//   rf_we_o/rf_addr_o/rf_data_o      register file write (stack pointer load)
//   cpu_rst_n_o, cpu_clk_en_o        CPU reset and CPU clock enable
//   halt_i, err_addr_i, err_miss_i   CPU stop causes
//   done_o, fault_o                  normal stop, image rejected
//   cycle_cnt_o                      saturating count of RUN cycles
module image_boot_ctrl #(
    parameter int IMEM_BYTES = 1024,
    parameter int DMEM_BYTES = 1024,
    parameter int SP_REG     = 29
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [31:0]                   in_data_i,
    output logic                          imem_we_o,
    output logic [$clog2(IMEM_BYTES)-1:0] imem_addr_o,
    output logic [7:0]                    imem_data_o,
    output logic                          dmem_we_o,
    output logic [$clog2(DMEM_BYTES)-1:0] dmem_addr_o,
    output logic [7:0]                    dmem_data_o,
    output logic                          pc_we_o,
    output logic [31:0]                   pc_o,
    output logic                          rf_we_o,
    output logic [4:0]                    rf_addr_o,
    output logic [31:0]                   rf_data_o,
    output logic                          cpu_rst_n_o,
    output logic                          cpu_clk_en_o,
    input  logic                          halt_i,
    input  logic                          err_addr_i,
    input  logic                          err_miss_i,
    output logic                          done_o,
    output logic                          fault_o,
    output logic [31:0]                   cycle_cnt_o
);

    localparam int          IAW       = $clog2(IMEM_BYTES);
    localparam int          DAW       = $clog2(DMEM_BYTES);
    localparam logic [31:0] IMAX      = 32'(IMEM_BYTES / 4);
    localparam logic [31:0] DMAX      = 32'(DMEM_BYTES / 4);
    localparam logic [4:0]  SP_IDX    = 5'(SP_REG);

    typedef enum logic [3:0] {
        S_I_PC,
        S_I_CNT,
        S_I_WORD,
        S_I_BYTE,
        S_D_SP,
        S_D_CNT,
        S_D_WORD,
        S_D_BYTE,
        S_D_CLEAR,
        S_RUN,
        S_STOP,
        S_FAULT
    } state_t;

    state_t          state;
    state_t          state_n;

    logic            accept;
    logic            load_word;
    logic            in_byte;
    logic            imem_wr;
    logic            dmem_byte_wr;
    logic            dmem_clr;
    logic [7:0]      byte_src;

    logic [31:0]     cnt;       // payload words still to be written
    logic [31:0]     shreg;     // remaining bytes of the current word, MSB first
    logic [1:0]      byte_cnt;  // index of the byte currently on the write port
    logic [IAW-1:0]  iptr;      // next instruction memory byte address
    logic [DAW-1:0]  dptr;      // next data memory byte address
    logic            dfull;     // data image covers all of data memory

    assign accept = in_valid_i && in_ready_o;

    // Next-state logic and the write strobes that the registers below act on
    always_comb begin
        state_n      = state;
        load_word    = 1'b0;
        in_byte      = 1'b0;
        imem_wr      = 1'b0;
        dmem_byte_wr = 1'b0;
        dmem_clr     = 1'b0;
        byte_src     = shreg[31:24];

        case (state)
            S_I_PC: begin
                if (accept) state_n = S_I_CNT;
            end
            S_I_CNT: begin
                if (accept) begin
                    if (in_data_i == '0)       state_n = S_D_SP;
                    else if (in_data_i > IMAX) state_n = S_FAULT;
                    else                       state_n = S_I_WORD;
                end
            end
            S_I_WORD: begin
                if (accept) begin
                    state_n   = S_I_BYTE;
                    load_word = 1'b1;
                end
            end
            S_I_BYTE: begin
                in_byte = 1'b1;
                if (byte_cnt == 2'd3) state_n = (cnt == 32'd1) ? S_D_SP : S_I_WORD;
            end
            S_D_SP: begin
                if (accept) state_n = S_D_CNT;
            end
            S_D_CNT: begin
                if (accept) begin
                    if (in_data_i > DMAX)      state_n = S_FAULT;
                    else if (in_data_i == '0)  state_n = S_D_CLEAR;
                    else                       state_n = S_D_WORD;
                end
            end
            S_D_WORD: begin
                if (accept) begin
                    state_n   = S_D_BYTE;
                    load_word = 1'b1;
                end
            end
            S_D_BYTE: begin
                in_byte = 1'b1;
                if (byte_cnt == 2'd3) begin
                    if (cnt != 32'd1)  state_n = S_D_WORD;
                    else if (dfull)    state_n = S_RUN;
                    else               state_n = S_D_CLEAR;
                end
            end
            S_D_CLEAR: begin
                // The address on the port is the one being cleared this cycle
                if (dmem_addr_o == '1) state_n = S_RUN;
            end
            S_RUN: begin
                if (halt_i || err_addr_i || err_miss_i) state_n = S_STOP;
            end
            default: state_n = state;
        endcase

        // Write ports are registered, so strobes follow the state being entered
        imem_wr      = (state_n == S_I_BYTE);
        dmem_byte_wr = (state_n == S_D_BYTE);
        dmem_clr     = (state_n == S_D_CLEAR);
        if (load_word) byte_src = in_data_i[31:24];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_I_PC;
        else        state <= state_n;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            in_ready_o   <= 1'b0;
            imem_we_o    <= 1'b0;
            imem_addr_o  <= '0;
            imem_data_o  <= '0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_data_o  <= '0;
            pc_we_o      <= 1'b0;
            pc_o         <= '0;
            rf_we_o      <= 1'b0;
            rf_addr_o    <= '0;
            rf_data_o    <= '0;
            cpu_rst_n_o  <= 1'b0;
            cpu_clk_en_o <= 1'b0;
            done_o       <= 1'b0;
            fault_o      <= 1'b0;
            cycle_cnt_o  <= '0;
            cnt          <= '0;
            shreg        <= '0;
            byte_cnt     <= '0;
            iptr         <= '0;
            dptr         <= '0;
            dfull        <= 1'b0;
        end else begin
            in_ready_o <= state_n inside {S_I_PC, S_I_CNT, S_I_WORD, S_D_SP, S_D_CNT, S_D_WORD};

            pc_we_o <= accept && (state == S_I_PC);
            if (accept && (state == S_I_PC)) begin
                pc_o <= in_data_i;
                iptr <= in_data_i[IAW-1:0];
            end

            rf_we_o <= accept && (state == S_D_SP);
            if (accept && (state == S_D_SP)) begin
                rf_addr_o <= SP_IDX;
                rf_data_o <= in_data_i;
                dptr      <= '0;
            end

            if (accept && (state == S_I_CNT || state == S_D_CNT)) cnt <= in_data_i;
            if (accept && (state == S_D_CNT)) dfull <= (in_data_i == DMAX);

            if (load_word) begin
                shreg    <= {in_data_i[23:0], 8'h00};
                byte_cnt <= 2'd0;
            end else if (in_byte) begin
                shreg    <= {shreg[23:0], 8'h00};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) cnt <= cnt - 32'd1;
            end

            imem_we_o <= imem_wr;
            if (imem_wr) begin
                imem_addr_o <= iptr;
                imem_data_o <= byte_src;
                iptr        <= iptr + IAW'(1);
            end

            dmem_we_o <= dmem_byte_wr || dmem_clr;
            if (dmem_byte_wr || dmem_clr) begin
                dmem_addr_o <= dptr;
                dmem_data_o <= dmem_clr ? 8'h00 : byte_src;
                dptr        <= dptr + DAW'(1);
            end

            cpu_rst_n_o  <= (state_n == S_RUN) || (state_n == S_STOP);
            cpu_clk_en_o <= (state_n == S_RUN);
            done_o       <= (state_n == S_STOP);
            fault_o      <= (state_n == S_FAULT);

            if ((state == S_RUN) && (cycle_cnt_o != '1)) cycle_cnt_o <= cycle_cnt_o + 32'd1;
        end
    end

endmodule
